// File: rtl/dma_burst_gen.sv
// dma_burst_gen: splits one DMA descriptor (start address, byte count,
// INCR/FIXED mode) into legal AXI4 burst requests on a valid/ready interface.
// INCR bursts never cross a 4 KB boundary and are capped at MAX_BEATS beats;
// FIXED bursts are capped at 16 beats.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   dma_go_i, dma_abort_i    start pulse; abort level (acts after current request)
//   desc_addr_i, desc_num_bytes_i, desc_mode_i   descriptor (mode 0=INCR, 1=FIXED)
//   req_valid_o/req_ready_i  burst request handshake
//   req_addr_o, req_len_o, req_size_o, req_burst_o, req_last_o   burst fields
//   busy_o, done_o, aborted_o, error_o, error_addr_o             status
module dma_burst_gen #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BYTES_WIDTH = 32,
  parameter int MAX_BEATS   = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dma_go_i,
  input  logic                   dma_abort_i,
  input  logic [ADDR_WIDTH-1:0]  desc_addr_i,
  input  logic [BYTES_WIDTH-1:0] desc_num_bytes_i,
  input  logic                   desc_mode_i,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic [ADDR_WIDTH-1:0]  req_addr_o,
  output logic [7:0]             req_len_o,
  output logic [2:0]             req_size_o,
  output logic [1:0]             req_burst_o,
  output logic                   req_last_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   aborted_o,
  output logic                   error_o,
  output logic [ADDR_WIDTH-1:0]  error_addr_o
);

  localparam int BPB = DATA_WIDTH / 8;
  localparam int SZ  = $clog2(BPB);
  localparam int BW  = BYTES_WIDTH - SZ;           // beat-count width
  localparam int CW  = (BW > 13) ? BW : 13;        // common compare width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic [BW-1:0]           beats_left_r, beats_left_s;
  logic                    mode_r, mode_s;
  logic [8:0]              cur_beats_r, cur_beats_s;
  logic                    req_valid_r, req_valid_s;
  logic [ADDR_WIDTH-1:0]   req_addr_r, req_addr_s;
  logic [7:0]              req_len_r, req_len_s;
  logic [1:0]              req_burst_r, req_burst_s;
  logic                    req_last_r, req_last_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    aborted_r, aborted_s;
  logic                    error_r, error_s;
  logic [ADDR_WIDTH-1:0]   error_addr_r, error_addr_s;

  logic                    bad_desc_s;
  logic [12:0]             to_bound_s;
  logic [12:0]             cap_s;
  logic [CW-1:0]           left_ext_s, cap_ext_s;
  logic [8:0]              beats_s;
  logic [BW-1:0]           new_left_s;

  // Burst sizing: beats remaining to the 4 KB boundary, mode cap, then min with beats_left.
  always_comb begin
    bad_desc_s = (desc_num_bytes_i == {BYTES_WIDTH{1'b0}}) ||
                 (desc_addr_i[SZ-1:0] != {SZ{1'b0}}) ||
                 (desc_num_bytes_i[SZ-1:0] != {SZ{1'b0}});
    to_bound_s = (13'h1000 - {1'b0, addr_r[11:0]}) >> SZ;
    if (mode_r) begin
      cap_s = 13'd16;
    end else if (to_bound_s < 13'(MAX_BEATS)) begin
      cap_s = to_bound_s;
    end else begin
      cap_s = 13'(MAX_BEATS);
    end
    left_ext_s = CW'(beats_left_r);
    cap_ext_s  = CW'(cap_s);
    if (left_ext_s < cap_ext_s) begin
      beats_s = 9'(left_ext_s);
    end else begin
      beats_s = 9'(cap_ext_s);
    end
    new_left_s = beats_left_r - BW'(cur_beats_r);
  end

  // Next-state and next-register logic of the descriptor FSM.
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    beats_left_s = beats_left_r;
    mode_s       = mode_r;
    cur_beats_s  = cur_beats_r;
    req_valid_s  = req_valid_r;
    req_addr_s   = req_addr_r;
    req_len_s    = req_len_r;
    req_burst_s  = req_burst_r;
    req_last_s   = req_last_r;
    done_s       = 1'b0;
    aborted_s    = 1'b0;
    error_s      = 1'b0;
    error_addr_s = error_addr_r;
    case (state_r)
      IDLE: begin
        if (dma_go_i) begin
          if (bad_desc_s) begin
            error_s      = 1'b1;
            error_addr_s = desc_addr_i;
          end else begin
            error_addr_s = {ADDR_WIDTH{1'b0}};
            addr_s       = desc_addr_i;
            beats_left_s = desc_num_bytes_i[BYTES_WIDTH-1:SZ];
            mode_s       = desc_mode_i;
            state_s      = CALC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (dma_abort_i) begin
          done_s    = 1'b1;
          aborted_s = 1'b1;
          state_s   = DONE;
        end else begin
          cur_beats_s = beats_s;
          req_valid_s = 1'b1;
          req_addr_s  = addr_r;
          req_len_s   = 8'(beats_s - 9'd1);
          req_burst_s = mode_r ? 2'b00 : 2'b01;
          req_last_s  = (beats_left_r == BW'(beats_s));
          state_s     = REQ;
        end
      end
      REQ: begin
        if (req_ready_i) begin
          req_valid_s  = 1'b0;
          beats_left_s = new_left_s;
          if (!mode_r) begin
            addr_s = addr_r + (ADDR_WIDTH'(cur_beats_r) << SZ);
          end else begin
            addr_s = addr_r;
          end
          if ((new_left_s == {BW{1'b0}}) || dma_abort_i) begin
            done_s    = 1'b1;
            aborted_s = dma_abort_i && (new_left_s != {BW{1'b0}});
            state_s   = DONE;
          end else begin
            state_s = CALC;
          end
        end else begin
          state_s = REQ;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s     = IDLE;
        req_valid_s = 1'b0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      beats_left_r <= {BW{1'b0}};
      mode_r       <= 1'b0;
      cur_beats_r  <= 9'd0;
      req_valid_r  <= 1'b0;
      req_addr_r   <= {ADDR_WIDTH{1'b0}};
      req_len_r    <= 8'd0;
      req_burst_r  <= 2'b00;
      req_last_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      error_r      <= 1'b0;
      error_addr_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r      <= state_s;
      addr_r       <= addr_s;
      beats_left_r <= beats_left_s;
      mode_r       <= mode_s;
      cur_beats_r  <= cur_beats_s;
      req_valid_r  <= req_valid_s;
      req_addr_r   <= req_addr_s;
      req_len_r    <= req_len_s;
      req_burst_r  <= req_burst_s;
      req_last_r   <= req_last_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      aborted_r    <= aborted_s;
      error_r      <= error_s;
      error_addr_r <= error_addr_s;
    end
  end

  assign req_valid_o  = req_valid_r;
  assign req_addr_o   = req_addr_r;
  assign req_len_o    = req_len_r;
  assign req_size_o   = 3'(SZ);
  assign req_burst_o  = req_burst_r;
  assign req_last_o   = req_last_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign aborted_o    = aborted_r;
  assign error_o      = error_r;
  assign error_addr_o = error_addr_r;

endmodule

// File: tb/tb_dma_burst_gen.sv
// Self-checking bench for dma_burst_gen (DATA_WIDTH=32, MAX_BEATS=256).
// Expected bursts come from a descriptor-level model that walks the byte
// range with plain arithmetic; stalls, aborts and descriptors are randomized.
module tb_dma_burst_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_go_i, dma_abort_i, desc_mode_i, req_ready_i;
  logic [31:0] desc_addr_i, desc_num_bytes_i;
  logic        req_valid_o, req_last_o, busy_o, done_o, aborted_o, error_o;
  logic [31:0] req_addr_o, error_addr_o;
  logic [7:0]  req_len_o;
  logic [2:0]  req_size_o;
  logic [1:0]  req_burst_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic        last;
  } burst_t;
  burst_t exp_q[$];

  dma_burst_gen dut (
    .clk(clk), .rst(rst), .dma_go_i(dma_go_i), .dma_abort_i(dma_abort_i),
    .desc_addr_i(desc_addr_i), .desc_num_bytes_i(desc_num_bytes_i),
    .desc_mode_i(desc_mode_i), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_addr_o(req_addr_o), .req_len_o(req_len_o), .req_size_o(req_size_o),
    .req_burst_o(req_burst_o), .req_last_o(req_last_o), .busy_o(busy_o),
    .done_o(done_o), .aborted_o(aborted_o), .error_o(error_o),
    .error_addr_o(error_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Descriptor-level model: walk the byte range, cutting at 4 KB pages,
  // 1 KB (256 beats x 4 B) for INCR, or 16 beats for FIXED.
  function automatic void build(input logic [31:0] a0, input int unsigned nbytes,
                                input logic fixed);
    int unsigned remaining, page_room, n;
    logic [31:0] a;
    burst_t b;
    exp_q.delete();
    remaining = nbytes;
    a = a0;
    while (remaining > 0) begin
      if (fixed) begin
        n = (remaining > 64) ? 64 : remaining;
      end else begin
        page_room = 4096 - (a % 4096);
        n = remaining;
        if (n > 1024) n = 1024;
        if (n > page_room) n = page_room;
      end
      b.addr  = a;
      b.len   = 8'(n / 4 - 1);
      b.burst = fixed ? 2'b00 : 2'b01;
      b.last  = (n == remaining);
      exp_q.push_back(b);
      remaining -= n;
      if (!fixed) a = a + n;
    end
  endfunction

  task automatic run_desc(input logic [31:0] a, input int unsigned nb, input logic md,
                          input int abort_idx, input bit busy_go);
    int n, stalls;
    bit ab, fin;
    build(a, nb, md);
    n = exp_q.size();
    @(negedge clk);
    dma_go_i = 1'b1; desc_addr_i = a; desc_num_bytes_i = nb; desc_mode_i = md;
    @(negedge clk);
    dma_go_i = 1'b0;
    chk("calc_valid", req_valid_o, 1'b0);
    chk("calc_busy", busy_o, 1'b1);
    @(negedge clk);
    fin = 1'b0;
    for (int i = 0; i < n && !fin; i++) begin
      chk("req_valid", req_valid_o, 1'b1);
      chk("req_addr", req_addr_o, exp_q[i].addr);
      chk("req_len", req_len_o, exp_q[i].len);
      chk("req_burst", req_burst_o, exp_q[i].burst);
      chk("req_size", req_size_o, 3'd2);
      chk("req_last", req_last_o, exp_q[i].last);
      stalls = $urandom_range(0, 3);
      if (busy_go && i == 0 && stalls == 0) stalls = 1;
      for (int s = 0; s < stalls; s++) begin
        if (busy_go && i == 0 && s == 0) begin
          dma_go_i = 1'b1; desc_addr_i = 32'h0000_0040; desc_num_bytes_i = 32'd4;
        end
        @(negedge clk);
        dma_go_i = 1'b0;
        chk("stall_valid", req_valid_o, 1'b1);
        chk("stall_addr", req_addr_o, exp_q[i].addr);
        chk("stall_len", req_len_o, exp_q[i].len);
        chk("stall_last", req_last_o, exp_q[i].last);
      end
      ab = (i == abort_idx);
      req_ready_i = 1'b1; dma_abort_i = ab;
      @(negedge clk);
      req_ready_i = 1'b0; dma_abort_i = 1'b0;
      chk("hs_valid", req_valid_o, 1'b0);
      if (i == n - 1 || ab) begin
        chk("done", done_o, 1'b1);
        chk("aborted", aborted_o, ab && (i != n - 1));
        fin = 1'b1;
        @(negedge clk);
        chk("done_pulse", done_o, 1'b0);
        chk("idle_busy", busy_o, 1'b0);
        chk("idle_valid", req_valid_o, 1'b0);
      end else begin
        chk("mid_done", done_o, 1'b0);
        chk("mid_busy", busy_o, 1'b1);
        @(negedge clk);
      end
    end
  endtask

  task automatic err_desc(input logic [31:0] a, input int unsigned nb);
    @(negedge clk);
    dma_go_i = 1'b1; desc_addr_i = a; desc_num_bytes_i = nb; desc_mode_i = 1'b0;
    @(negedge clk);
    dma_go_i = 1'b0;
    chk("err_pulse", error_o, 1'b1);
    chk("err_addr", error_addr_o, a);
    chk("err_busy", busy_o, 1'b0);
    chk("err_valid", req_valid_o, 1'b0);
    @(negedge clk);
    chk("err_clear", error_o, 1'b0);
    chk("err_addr_hold", error_addr_o, a);
    chk("err_valid2", req_valid_o, 1'b0);
  endtask

  initial begin
    logic [31:0] ra;
    int unsigned rb;
    rst = 1'b1; dma_go_i = 1'b0; dma_abort_i = 1'b0; desc_mode_i = 1'b0;
    req_ready_i = 1'b0; desc_addr_i = 32'h0; desc_num_bytes_i = 32'h0;
    #12;
    chk("rst_valid", req_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_size", req_size_o, 3'd2);
    chk("rst_len", req_len_o, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // abort while idle is ignored
    @(negedge clk); dma_abort_i = 1'b1;
    @(negedge clk); dma_abort_i = 1'b0;
    chk("idle_abort_busy", busy_o, 1'b0);

    run_desc(32'h0000_1000, 16, 1'b0, -1, 1'b0);
    run_desc(32'h0000_0FF0, 64, 1'b0, -1, 1'b0);
    run_desc(32'h0000_0000, 2048, 1'b0, -1, 1'b0);
    run_desc(32'h0000_2000, 80, 1'b1, -1, 1'b0);
    run_desc(32'hFFFF_FF00, 512, 1'b0, -1, 1'b0);
    err_desc(32'h0000_3000, 0);
    err_desc(32'h0000_1002, 8);
    err_desc(32'h0000_1000, 6);
    run_desc(32'h0000_5000, 3072, 1'b0, -1, 1'b1);
    run_desc(32'h0000_0000, 3072, 1'b0, 1, 1'b0);
    run_desc(32'h0000_8000, 64, 1'b1, 0, 1'b0);

    // abort while in CALC: no request, aborted completion
    @(negedge clk);
    dma_go_i = 1'b1; desc_addr_i = 32'h0000_4000; desc_num_bytes_i = 32'd64; desc_mode_i = 1'b0;
    @(negedge clk);
    dma_go_i = 1'b0; dma_abort_i = 1'b1;
    @(negedge clk);
    dma_abort_i = 1'b0;
    chk("calc_abort_valid", req_valid_o, 1'b0);
    chk("calc_abort_done", done_o, 1'b1);
    chk("calc_abort_aborted", aborted_o, 1'b1);
    @(negedge clk);
    chk("calc_abort_idle", busy_o, 1'b0);

    // reset while a request is pending
    @(negedge clk);
    dma_go_i = 1'b1; desc_addr_i = 32'h0000_0000; desc_num_bytes_i = 32'd2048; desc_mode_i = 1'b0;
    @(negedge clk); dma_go_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", req_valid_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", req_valid_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_len", req_len_o, 8'd0);
    chk("arst_last", req_last_o, 1'b0);
    chk("arst_done", done_o, 1'b0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_done", done_o, 1'b0);
      chk("post_rst_valid", req_valid_o, 1'b0);
    end

    // randomized descriptors, often placed near a page end
    for (int t = 0; t < 30; t++) begin
      ra = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 1)
        ra = {ra[31:12], 12'hE00 | (ra[11:0] & 12'h1FC)};
      rb = $urandom_range(1, 800) * 4;
      run_desc(ra, rb, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
